// File: rtl/commit_ctrl_pkg.sv
// Shared constants, types and FSM encoding for the commit controller.
package commit_ctrl_pkg;

  localparam int RRF_SEL   = 6;
  localparam int REG_SEL   = 5;
  localparam int TAG_W     = RRF_SEL;
  localparam int REG_W     = REG_SEL;
  localparam int ENTRY_NUM = 1 << RRF_SEL;

  typedef logic [TAG_W-1:0] tag_t;
  typedef logic [REG_W-1:0] reg_t;
  typedef logic [TAG_W:0]   occ_t;

  typedef enum logic [1:0] {
    RUN     = 2'd0,
    DRAIN   = 2'd1,
    DRAINED = 2'd2
  } state_e;

endpackage

// File: rtl/commit_ctrl_if.sv
// Dispatch/finish/control inputs and completion outputs of the commit controller.
interface commit_ctrl_if;
  import commit_ctrl_pkg::*;

  logic dp_we_i;
  tag_t dp_tag_i;
  logic dp_dst_en_i;
  reg_t dp_dst_num_i;
  logic fin_we_i;
  tag_t fin_tag_i;
  logic freeze_i;
  logic drain_req_i;
  logic completed_we_o;
  reg_t completed_dstnum_o;
  tag_t completed_rrftag_o;
  logic [1:0] com_inst_num_o;
  tag_t comptr_o;
  occ_t occupancy_o;
  logic drained_o;
  logic err_o;

  modport master (
    output dp_we_i, dp_tag_i, dp_dst_en_i, dp_dst_num_i,
    output fin_we_i, fin_tag_i, freeze_i, drain_req_i,
    input  completed_we_o, completed_dstnum_o, completed_rrftag_o,
    input  com_inst_num_o, comptr_o, occupancy_o, drained_o, err_o
  );

  modport slave (
    input  dp_we_i, dp_tag_i, dp_dst_en_i, dp_dst_num_i,
    input  fin_we_i, fin_tag_i, freeze_i, drain_req_i,
    output completed_we_o, completed_dstnum_o, completed_rrftag_o,
    output com_inst_num_o, comptr_o, occupancy_o, drained_o, err_o
  );

endinterface

// File: rtl/commit_entry_table.sv
// Per-entry valid/finished/destination storage indexed by RRF tag.
module commit_entry_table
  import commit_ctrl_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic wr_en,
  input  tag_t wr_tag,
  input  logic wr_dst_en,
  input  reg_t wr_dst_num,
  input  logic set_en,
  input  tag_t set_tag,
  input  logic clr_en,
  input  tag_t clr_tag,
  input  tag_t head_tag,
  output logic head_valid,
  output logic head_finished,
  output logic head_dst_en,
  output reg_t head_dst_num,
  output logic wr_hit,
  output logic set_hit
);

  logic [ENTRY_NUM-1:0] valid;
  logic [ENTRY_NUM-1:0] finished;
  logic [ENTRY_NUM-1:0] dst_en;
  reg_t dst_num [ENTRY_NUM];

  // Status bits: clear on commit, set on finish of a live entry, dispatch overrides both.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid    <= '0;
      finished <= '0;
      dst_en   <= '0;
    end else begin
      if (clr_en)
        valid[clr_tag] <= 1'b0;
      if (set_en && valid[set_tag])
        finished[set_tag] <= 1'b1;
      if (wr_en) begin
        valid[wr_tag]    <= 1'b1;
        finished[wr_tag] <= 1'b0;
        dst_en[wr_tag]   <= wr_dst_en;
      end
    end
  end

  // Destination register numbers are only meaningful while valid, so they need no reset.
  always_ff @(posedge clk) begin
    if (wr_en)
      dst_num[wr_tag] <= wr_dst_num;
  end

  assign head_valid    = valid[head_tag];
  assign head_finished = finished[head_tag];
  assign head_dst_en   = dst_en[head_tag];
  assign head_dst_num  = dst_num[head_tag];
  assign wr_hit        = valid[wr_tag];
  assign set_hit       = valid[set_tag];

endmodule

// File: rtl/commit_ctrl.sv
// In-order retirement controller: owns the commit pointer, occupancy and drain FSM.
module commit_ctrl
  import commit_ctrl_pkg::*;
(
  input logic    clk_i,
  input logic    reset_i,
  commit_ctrl_if.slave bus
);

  state_e state, state_next;
  tag_t   comptr;
  occ_t   occupancy, occ_next;
  logic   head_valid, head_finished, head_dst_en;
  reg_t   head_dst_num;
  logic   wr_hit, set_hit;
  logic   commit, overwrite, occ_inc, err_set;
  logic   completed_we, drained, err;
  reg_t   completed_dstnum;
  tag_t   completed_rrftag;
  logic [1:0] com_inst_num;

  commit_entry_table u_table (
    .clk          (clk_i),
    .rst_n        (reset_i),
    .wr_en        (bus.dp_we_i),
    .wr_tag       (bus.dp_tag_i),
    .wr_dst_en    (bus.dp_dst_en_i),
    .wr_dst_num   (bus.dp_dst_num_i),
    .set_en       (bus.fin_we_i),
    .set_tag      (bus.fin_tag_i),
    .clr_en       (commit),
    .clr_tag      (comptr),
    .head_tag     (comptr),
    .head_valid   (head_valid),
    .head_finished(head_finished),
    .head_dst_en  (head_dst_en),
    .head_dst_num (head_dst_num),
    .wr_hit       (wr_hit),
    .set_hit      (set_hit)
  );

  // Commit decision, occupancy update, error detection and drain FSM next state.
  always_comb begin
    commit     = head_valid & head_finished & ~bus.freeze_i;
    overwrite  = bus.dp_we_i & wr_hit & ~(commit & (bus.dp_tag_i == comptr));
    occ_inc    = bus.dp_we_i & ~overwrite;
    occ_next   = occupancy;
    if (occ_inc && !commit)
      occ_next = occupancy + occ_t'(1);
    else if (!occ_inc && commit)
      occ_next = occupancy - occ_t'(1);
    err_set    = (bus.fin_we_i & ~set_hit) | overwrite |
                 (bus.dp_we_i & (occupancy == occ_t'(ENTRY_NUM)) & ~commit) |
                 (bus.dp_we_i & (state != RUN));
    state_next = state;
    case (state)
      RUN:     if (bus.drain_req_i) state_next = DRAIN;
      DRAIN:   if (!bus.drain_req_i) state_next = RUN;
               else if (occ_next == '0) state_next = DRAINED;
      DRAINED: if (!bus.drain_req_i) state_next = RUN;
      default: state_next = RUN;
    endcase
  end

  // Pointer, occupancy, FSM, sticky error and registered completion outputs.
  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      state            <= RUN;
      comptr           <= '0;
      occupancy        <= '0;
      drained          <= 1'b0;
      err              <= 1'b0;
      completed_we     <= 1'b0;
      completed_dstnum <= '0;
      completed_rrftag <= '0;
      com_inst_num     <= 2'd0;
    end else begin
      state     <= state_next;
      occupancy <= occ_next;
      drained   <= (state_next == DRAINED);
      if (err_set)
        err <= 1'b1;
      if (commit) begin
        comptr           <= comptr + tag_t'(1);
        completed_we     <= head_dst_en;
        completed_dstnum <= head_dst_num;
        completed_rrftag <= comptr;
        com_inst_num     <= 2'd1;
      end else begin
        completed_we     <= 1'b0;
        com_inst_num     <= 2'd0;
      end
    end
  end

  assign bus.completed_we_o     = completed_we;
  assign bus.completed_dstnum_o = completed_dstnum;
  assign bus.completed_rrftag_o = completed_rrftag;
  assign bus.com_inst_num_o     = com_inst_num;
  assign bus.comptr_o           = comptr;
  assign bus.occupancy_o        = occupancy;
  assign bus.drained_o          = drained;
  assign bus.err_o              = err;

endmodule

// File: tb/tb_commit_ctrl.sv
// Directed testbench for commit_ctrl with hand-computed expectations.
module tb_commit_ctrl;
  import commit_ctrl_pkg::*;

  logic clk_i;
  logic reset_i;
  int   total;
  int   bad;

  commit_ctrl_if bus ();

  commit_ctrl dut (
    .clk_i  (clk_i),
    .reset_i(reset_i),
    .bus    (bus)
  );

  // 10 ns clock.
  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  // Global watchdog so the run always ends.
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: got timeout required finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic idle_inputs();
    bus.dp_we_i      = 1'b0;
    bus.dp_tag_i     = '0;
    bus.dp_dst_en_i  = 1'b0;
    bus.dp_dst_num_i = '0;
    bus.fin_we_i     = 1'b0;
    bus.fin_tag_i    = '0;
    bus.freeze_i     = 1'b0;
    bus.drain_req_i  = 1'b0;
  endtask

  task automatic do_reset();
    idle_inputs();
    reset_i = 1'b0;
    repeat (2) @(posedge clk_i);
    #1;
    reset_i = 1'b1;
  endtask

  task automatic dispatch(input int tag, input logic en, input int num);
    bus.dp_we_i      = 1'b1;
    bus.dp_tag_i     = tag_t'(tag);
    bus.dp_dst_en_i  = en;
    bus.dp_dst_num_i = reg_t'(num);
  endtask

  task automatic finish(input int tag);
    bus.fin_we_i  = 1'b1;
    bus.fin_tag_i = tag_t'(tag);
  endtask

  task automatic test_reset();
    do_reset();
    dispatch(0, 1'b1, 12);
    tick();
    bus.dp_we_i = 1'b0;
    finish(0);
    tick();
    bus.fin_we_i = 1'b0;
    #2 reset_i = 1'b0;
    #1;
    total++; if (bus.completed_we_o !== 1'b0) begin bad++; $display("[TB] FAIL rst_we: got %0d required 0", bus.completed_we_o); end
    total++; if (bus.com_inst_num_o !== 2'd0) begin bad++; $display("[TB] FAIL rst_num: got %0d required 0", bus.com_inst_num_o); end
    total++; if (bus.completed_dstnum_o !== 5'd0) begin bad++; $display("[TB] FAIL rst_dstnum: got %0d required 0", bus.completed_dstnum_o); end
    total++; if (bus.completed_rrftag_o !== 6'd0) begin bad++; $display("[TB] FAIL rst_rrftag: got %0d required 0", bus.completed_rrftag_o); end
    total++; if (bus.comptr_o !== 6'd0) begin bad++; $display("[TB] FAIL rst_comptr: got %0d required 0", bus.comptr_o); end
    total++; if (bus.occupancy_o !== 7'd0) begin bad++; $display("[TB] FAIL rst_occ: got %0d required 0", bus.occupancy_o); end
    total++; if (bus.drained_o !== 1'b0 || bus.err_o !== 1'b0) begin bad++; $display("[TB] FAIL rst_flags: got drained=%0d err=%0d required 0 0", bus.drained_o, bus.err_o); end
    reset_i = 1'b1;
    tick();
    total++; if (bus.com_inst_num_o !== 2'd0) begin bad++; $display("[TB] FAIL rst_no_pulse1: got %0d required 0", bus.com_inst_num_o); end
    tick();
    total++; if (bus.com_inst_num_o !== 2'd0 || bus.comptr_o !== 6'd0) begin bad++; $display("[TB] FAIL rst_no_pulse2: got num=%0d comptr=%0d required 0 0", bus.com_inst_num_o, bus.comptr_o); end
  endtask

  task automatic test_basic_commit();
    do_reset();
    dispatch(0, 1'b1, 5);
    tick();
    bus.dp_we_i = 1'b0;
    total++; if (bus.occupancy_o !== 7'd1) begin bad++; $display("[TB] FAIL basic_occ1: got %0d required 1", bus.occupancy_o); end
    tick();
    finish(0);
    tick();
    bus.fin_we_i = 1'b0;
    total++; if (bus.com_inst_num_o !== 2'd0) begin bad++; $display("[TB] FAIL basic_no_bypass: got %0d required 0", bus.com_inst_num_o); end
    tick();
    total++; if (bus.completed_we_o !== 1'b1) begin bad++; $display("[TB] FAIL basic_we: got %0d required 1", bus.completed_we_o); end
    total++; if (bus.completed_dstnum_o !== 5'd5) begin bad++; $display("[TB] FAIL basic_dstnum: got %0d required 5", bus.completed_dstnum_o); end
    total++; if (bus.completed_rrftag_o !== 6'd0) begin bad++; $display("[TB] FAIL basic_rrftag: got %0d required 0", bus.completed_rrftag_o); end
    total++; if (bus.com_inst_num_o !== 2'd1) begin bad++; $display("[TB] FAIL basic_num: got %0d required 1", bus.com_inst_num_o); end
    total++; if (bus.comptr_o !== 6'd1) begin bad++; $display("[TB] FAIL basic_comptr: got %0d required 1", bus.comptr_o); end
    total++; if (bus.occupancy_o !== 7'd0) begin bad++; $display("[TB] FAIL basic_occ0: got %0d required 0", bus.occupancy_o); end
    tick();
    total++; if (bus.completed_we_o !== 1'b0 || bus.com_inst_num_o !== 2'd0) begin bad++; $display("[TB] FAIL basic_idle: got we=%0d num=%0d required 0 0", bus.completed_we_o, bus.com_inst_num_o); end
    total++; if (bus.completed_dstnum_o !== 5'd5) begin bad++; $display("[TB] FAIL basic_hold: got %0d required 5", bus.completed_dstnum_o); end
  endtask

  task automatic test_in_order();
    int order [4] = '{3, 1, 2, 0};
    do_reset();
    for (int i = 0; i < 4; i++) begin
      dispatch(i, 1'b1, 10 + i);
      tick();
    end
    bus.dp_we_i = 1'b0;
    total++; if (bus.occupancy_o !== 7'd4) begin bad++; $display("[TB] FAIL order_occ4: got %0d required 4", bus.occupancy_o); end
    for (int i = 0; i < 4; i++) begin
      finish(order[i]);
      tick();
      total++; if (bus.com_inst_num_o !== 2'd0) begin bad++; $display("[TB] FAIL order_wait%0d: got %0d required 0", i, bus.com_inst_num_o); end
    end
    bus.fin_we_i = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      total++; if (bus.com_inst_num_o !== 2'd1 || bus.completed_rrftag_o !== tag_t'(i) || bus.completed_dstnum_o !== reg_t'(10 + i)) begin
        bad++; $display("[TB] FAIL order_commit%0d: got num=%0d tag=%0d dst=%0d required 1 %0d %0d", i, bus.com_inst_num_o, bus.completed_rrftag_o, bus.completed_dstnum_o, i, 10 + i);
      end
    end
    tick();
    total++; if (bus.com_inst_num_o !== 2'd0 || bus.comptr_o !== 6'd4 || bus.occupancy_o !== 7'd0) begin bad++; $display("[TB] FAIL order_end: got num=%0d comptr=%0d occ=%0d required 0 4 0", bus.com_inst_num_o, bus.comptr_o, bus.occupancy_o); end
  endtask

  task automatic test_wrap_nodest();
    do_reset();
    for (int i = 0; i < 63; i++) begin
      dispatch(i, 1'b1, 1);
      tick();
      bus.dp_we_i = 1'b0;
      finish(i);
      tick();
      bus.fin_we_i = 1'b0;
      tick();
    end
    total++; if (bus.comptr_o !== 6'd63 || bus.occupancy_o !== 7'd0) begin bad++; $display("[TB] FAIL wrap_pre: got comptr=%0d occ=%0d required 63 0", bus.comptr_o, bus.occupancy_o); end
    dispatch(63, 1'b0, 7);
    tick();
    dispatch(0, 1'b1, 9);
    tick();
    bus.dp_we_i = 1'b0;
    finish(63);
    tick();
    finish(0);
    tick();
    bus.fin_we_i = 1'b0;
    total++; if (bus.com_inst_num_o !== 2'd1 || bus.completed_we_o !== 1'b0) begin bad++; $display("[TB] FAIL wrap_nodest: got num=%0d we=%0d required 1 0", bus.com_inst_num_o, bus.completed_we_o); end
    total++; if (bus.completed_rrftag_o !== 6'd63 || bus.comptr_o !== 6'd0) begin bad++; $display("[TB] FAIL wrap_tag63: got tag=%0d comptr=%0d required 63 0", bus.completed_rrftag_o, bus.comptr_o); end
    tick();
    total++; if (bus.com_inst_num_o !== 2'd1 || bus.completed_we_o !== 1'b1 || bus.completed_rrftag_o !== 6'd0) begin bad++; $display("[TB] FAIL wrap_tag0: got num=%0d we=%0d tag=%0d required 1 1 0", bus.com_inst_num_o, bus.completed_we_o, bus.completed_rrftag_o); end
    total++; if (bus.comptr_o !== 6'd1 || bus.completed_dstnum_o !== 5'd9) begin bad++; $display("[TB] FAIL wrap_comptr: got comptr=%0d dst=%0d required 1 9", bus.comptr_o, bus.completed_dstnum_o); end
    total++; if (bus.err_o !== 1'b0) begin bad++; $display("[TB] FAIL wrap_err: got %0d required 0", bus.err_o); end
  endtask

  task automatic test_freeze();
    do_reset();
    dispatch(0, 1'b1, 3);
    tick();
    dispatch(1, 1'b1, 4);
    tick();
    bus.dp_we_i = 1'b0;
    finish(0);
    tick();
    bus.freeze_i = 1'b1;
    finish(1);
    tick();
    bus.fin_we_i = 1'b0;
    total++; if (bus.com_inst_num_o !== 2'd0) begin bad++; $display("[TB] FAIL freeze_c0: got %0d required 0", bus.com_inst_num_o); end
    for (int i = 1; i < 3; i++) begin
      tick();
      total++; if (bus.com_inst_num_o !== 2'd0 || bus.completed_we_o !== 1'b0) begin bad++; $display("[TB] FAIL freeze_c%0d: got num=%0d we=%0d required 0 0", i, bus.com_inst_num_o, bus.completed_we_o); end
    end
    bus.freeze_i = 1'b0;
    tick();
    total++; if (bus.com_inst_num_o !== 2'd1 || bus.completed_rrftag_o !== 6'd0) begin bad++; $display("[TB] FAIL freeze_resume0: got num=%0d tag=%0d required 1 0", bus.com_inst_num_o, bus.completed_rrftag_o); end
    tick();
    total++; if (bus.com_inst_num_o !== 2'd1 || bus.completed_rrftag_o !== 6'd1 || bus.completed_dstnum_o !== 5'd4) begin bad++; $display("[TB] FAIL freeze_resume1: got num=%0d tag=%0d dst=%0d required 1 1 4", bus.com_inst_num_o, bus.completed_rrftag_o, bus.completed_dstnum_o); end
  endtask

  task automatic test_drain();
    do_reset();
    dispatch(0, 1'b1, 1);
    tick();
    dispatch(1, 1'b1, 2);
    tick();
    bus.dp_we_i = 1'b0;
    bus.drain_req_i = 1'b1;
    tick();
    total++; if (bus.drained_o !== 1'b0) begin bad++; $display("[TB] FAIL drain_early: got %0d required 0", bus.drained_o); end
    finish(0);
    tick();
    finish(1);
    tick();
    bus.fin_we_i = 1'b0;
    total++; if (bus.drained_o !== 1'b0 || bus.occupancy_o !== 7'd1) begin bad++; $display("[TB] FAIL drain_mid: got drained=%0d occ=%0d required 0 1", bus.drained_o, bus.occupancy_o); end
    tick();
    total++; if (bus.drained_o !== 1'b1 || bus.occupancy_o !== 7'd0 || bus.comptr_o !== 6'd2) begin bad++; $display("[TB] FAIL drain_done: got drained=%0d occ=%0d comptr=%0d required 1 0 2", bus.drained_o, bus.occupancy_o, bus.comptr_o); end
    bus.drain_req_i = 1'b0;
    tick();
    total++; if (bus.drained_o !== 1'b0) begin bad++; $display("[TB] FAIL drain_release: got %0d required 0", bus.drained_o); end
    dispatch(2, 1'b1, 3);
    tick();
    bus.dp_we_i = 1'b0;
    total++; if (bus.err_o !== 1'b0) begin bad++; $display("[TB] FAIL drain_run_dispatch: got err=%0d required 0", bus.err_o); end
    bus.drain_req_i = 1'b1;
    tick();
    dispatch(3, 1'b1, 4);
    tick();
    bus.dp_we_i = 1'b0;
    total++; if (bus.err_o !== 1'b1) begin bad++; $display("[TB] FAIL drain_dispatch_err: got %0d required 1", bus.err_o); end
    bus.drain_req_i = 1'b0;
  endtask

  task automatic test_errors();
    do_reset();
    finish(5);
    tick();
    bus.fin_we_i = 1'b0;
    total++; if (bus.err_o !== 1'b1 || bus.occupancy_o !== 7'd0) begin bad++; $display("[TB] FAIL err_fin_invalid: got err=%0d occ=%0d required 1 0", bus.err_o, bus.occupancy_o); end
    repeat (3) tick();
    total++; if (bus.err_o !== 1'b1 || bus.com_inst_num_o !== 2'd0) begin bad++; $display("[TB] FAIL err_sticky: got err=%0d num=%0d required 1 0", bus.err_o, bus.com_inst_num_o); end
    do_reset();
    for (int i = 0; i < 64; i++) begin
      dispatch(i, 1'b1, i % 32);
      tick();
    end
    bus.dp_we_i = 1'b0;
    total++; if (bus.err_o !== 1'b0 || bus.occupancy_o !== 7'd64) begin bad++; $display("[TB] FAIL err_full_pre: got err=%0d occ=%0d required 0 64", bus.err_o, bus.occupancy_o); end
    dispatch(0, 1'b1, 1);
    tick();
    bus.dp_we_i = 1'b0;
    total++; if (bus.err_o !== 1'b1) begin bad++; $display("[TB] FAIL err_full: got %0d required 1", bus.err_o); end
  endtask

  // Scenario sequence and summary.
  initial begin
    total = 0;
    bad   = 0;
    reset_i = 1'b1;
    idle_inputs();
    test_reset();
    test_basic_commit();
    test_in_order();
    test_wrap_nodest();
    test_freeze();
    test_drain();
    test_errors();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/commit_ctrl.md
# commit_ctrl

In-order retirement controller for the rename datapath. Tracks up to ENTRY_NUM in-flight instructions indexed by RRF tag, using per-entry dispatch and finish state. Retires the head entry once finished, at most one per cycle, driving the rename unit's ARF completion port and the RRF allocator's commit count. Sits between dispatch/execute and the rename unit and owns the commit pointer.

## Interface
Parameters:
- ENTRY_NUM, 64: tracked entries, equal to the RRF depth; power of two.
- TAG_W, 6: log2(ENTRY_NUM); RRF tag width.
- REG_W, 5: architectural register index width.

Ports:
- clk_i  in  1  single clock, rising edge.
- reset_i  in  1  asynchronous, active-low reset.
- dp_we_i  in  1  dispatch writes one entry this cycle.
- dp_tag_i  in  TAG_W  entry written; equals the allocator's rename tag.
- dp_dst_en_i  in  1  instruction writes an architectural register.
- dp_dst_num_i  in  REG_W  architectural destination.
- fin_we_i  in  1  an execute unit finished an instruction.
- fin_tag_i  in  TAG_W  tag of the finished instruction.
- freeze_i  in  1  block commits while high.
- drain_req_i  in  1  request to retire everything outstanding.
- completed_we_o  out  1  ARF completion write enable.
- completed_dstnum_o  out  REG_W  ARF register to release.
- completed_rrftag_o  out  TAG_W  RRF tag being committed.
- com_inst_num_o  out  2  instructions committed this cycle, 0 or 1; feeds the RRF allocator.
- comptr_o  out  TAG_W  current head (commit pointer).
- occupancy_o  out  TAG_W+1  number of valid entries.
- drained_o  out  1  drain complete.
- err_o  out  1  sticky protocol error.

## Operation
- Per-entry state: valid, finished, dst_en, dst_num.
- **Dispatch:** sets valid=1, finished=0, and records dst_en and dst_num.
- **Finish:** sets finished=1 on a valid entry.
  - A finish to an invalid entry sets err_o and has no effect.
- **Commit condition:** valid[comptr] & finished[comptr] & !freeze_i.
- **On commit:**
  - Clear valid[comptr].
  - comptr increments modulo ENTRY_NUM, wrapping 63→0.
  - Registered outputs for the next cycle:
    - com_inst_num_o=1.
    - completed_rrftag_o=comptr.
    - completed_dstnum_o=dst_num.
    - completed_we_o=dst_en.
  - Entries with dst_en=0 still commit and still count in com_inst_num_o.
- **Otherwise:** completed_we_o=0 and com_inst_num_o=0. The tag and dstnum outputs hold their last values.
- **Occupancy:** occupancy_o is +1 on dispatch and −1 on commit; both in the same cycle leaves it unchanged.
- **Dispatch errors:** dispatch to an entry that is valid and not committing this cycle sets err_o; the entry is overwritten. Dispatch with occupancy_o==ENTRY_NUM and no commit also sets err_o.
- **State machine (RUN, DRAIN, DRAINED):**
  - RUN→DRAIN when drain_req_i=1.
  - DRAIN→DRAINED when occupancy is 0, or when the commit in progress brings it to 0.
  - DRAINED asserts drained_o=1.
  - DRAINED→RUN when drain_req_i=0.
  - DRAIN→RUN if drain_req_i drops before DRAINED.
  - Commits continue normally in DRAIN. A dispatch in DRAIN or DRAINED sets err_o.
  - freeze_i blocks commits in every state; it does not change state.
- **err_o** clears only on reset.

## Timing
- Reset (asynchronous assert, synchronous-release-safe):
  - All valid and finished bits are 0.
  - comptr_o=0, occupancy_o=0.
  - completed_we_o=0, completed_dstnum_o=0, completed_rrftag_o=0, com_inst_num_o=0.
  - drained_o=0, err_o=0, state RUN.
- Reset mid-operation discards all entries with no commit pulse.
- **Finish latency:** a finish at edge N makes the commit decision in cycle N+1. completed_we_o and com_inst_num_o are visible in cycle N+2. fin_we_i is not bypassed into the same-cycle decision.
- **Dispatch and finish, same tag, same cycle:** finish is ignored and err_o is set (the entry was invalid before the edge).
- **Throughput:** back-to-back commits, one per cycle, when consecutive heads are finished.
- **Freeze:** rising at any cycle suppresses that cycle's commit. The outputs for the following cycle are then 0.
- drained_o is registered and asserts the cycle after occupancy reaches 0 in DRAIN.

## Structure
- Shared package: ENTRY_NUM, TAG_W and REG_W, tied to the existing RRF_SEL/REG_SEL constants. FSM state encoding: RUN=0, DRAIN=1, DRAINED=2.
- One natural sub-module: commit_entry_table, holding the valid/finished/dst arrays with one write port for dispatch, one set port for finish and one clear port for commit, plus a combinational head read.
- The FSM, pointers and occupancy live in the top level.

## Test plan
- **Reset:** reset_i=0 mid-traffic → all outputs 0, occupancy_o=0, no commit pulse after release.
- **Basic commit:** dispatch tag 0 (dst x5, en=1), finish tag 0 at cycle 3 → cycle 5 shows completed_we_o=1, dstnum=5, rrftag=0, com_inst_num_o=1; comptr_o=1.
- **In-order retirement:** dispatch tags 0–3, finish order 3,1,2,0 → four consecutive commits with rrftag 0,1,2,3 in order, starting 2 cycles after tag 0 finishes.
- **Wrap and no-dest:** advance comptr to 63, dispatch tag 63 with dst_en=0 and tag 0 → commit tag 63 shows completed_we_o=0 and com_inst_num_o=1; next cycle commits tag 0 and comptr_o=1.
- **Freeze and drain:**
  - freeze_i high for 3 cycles with a finished head → no commits during the freeze; commits resume the cycle after release.
  - drain_req_i with 2 entries outstanding → drained_o=1 after both commit.
  - Dropping drain_req_i returns the FSM to RUN.
- **Errors:** finish to an invalid tag → err_o=1 and stays high. Dispatch at full occupancy → err_o=1.
